// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte producers, with packet lock.
// Optional handshake timeout enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ack,
  output logic [2:0]                  grant_id,
  output logic [DATA_W-1:0]           tx_data,
  output logic                        tx_start,
  input  logic                        tx_busy,
  output logic                        err_timeout
);

  // state | meaning
  // IDLE  | arbitrate among requesters
  // START | tx_start high, waiting for synchronized busy
  // BUSY  | waiting for synchronized busy to fall
  // ACK   | one-cycle req_ack to the owner
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  logic [1:0]        state;
  logic              busy_q;
  logic              busy_s;
  logic              lock;
  logic [2:0]        last;
  logic              sel_valid;
  logic [2:0]        sel;
  logic              abort;
  logic [7:0]        req_x;
  logic [7:0]        last_x;
  logic [DATA_W-1:0] data_arr [8];
  int                idx;

  // Widen per-requester vectors to 8 entries so a 3-bit index always fits.
  always_comb begin
    req_x  = '0;
    last_x = '0;
    req_x[NUM_REQ-1:0]  = req;
    last_x[NUM_REQ-1:0] = req_last;
    for (int i = 0; i < 8; i++) data_arr[i] = '0;
    for (int i = 0; i < NUM_REQ; i++) data_arr[i] = req_data[i*DATA_W +: DATA_W];
  end

  always_comb begin
    sel_valid = 1'b0;
    sel       = grant_id;
    idx       = 0;
    if (lock && req_x[grant_id]) begin
      sel_valid = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = int'(last) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!sel_valid && req_x[3'(idx)]) begin
          sel_valid = 1'b1;
          sel       = 3'(idx);
        end
      end
    end
  end

  assign tx_start = (state == S_START);

  always_comb begin
    req_ack = '0;
    if (state == S_ACK) begin
      for (int i = 0; i < NUM_REQ; i++) req_ack[i] = (grant_id == 3'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy_q   <= 1'b0;
      busy_s   <= 1'b0;
      lock     <= 1'b0;
      last     <= 3'(NUM_REQ - 1);
      grant_id <= 3'd0;
      tx_data  <= '0;
    end else begin
      busy_q <= tx_busy;
      busy_s <= busy_q;
      case (state)
        S_IDLE: begin
          if (lock && !req_x[grant_id]) lock <= 1'b0;
          if (sel_valid) begin
            tx_data  <= data_arr[sel];
            grant_id <= sel;
            last     <= sel;
            lock     <= ~last_x[sel];
            state    <= S_START;
          end
        end
        S_START: begin
          if (abort) begin
            lock  <= 1'b0;
            state <= S_ACK;
          end else if (busy_s) begin
            state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (abort) begin
            lock  <= 1'b0;
            state <= S_ACK;
          end else if (!busy_s) begin
            state <= S_ACK;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  logic [31:0] to_cnt;
  logic        err_q;

  // Counter restarts with every new grant; abort fires on the cycle it reaches the limit.
  assign abort       = ((state == S_START) || (state == S_BUSY)) && (to_cnt == 32'(TIMEOUT_CYC - 1));
  assign err_timeout = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if ((state == S_IDLE) && sel_valid) begin
        to_cnt <= '0;
      end else if ((state == S_START) || (state == S_BUSY)) begin
        to_cnt <= to_cnt + 32'd1;
      end
      if (abort) err_q <= 1'b1;
    end
  end
`else
  assign abort       = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued requesters, a delayed-busy transmitter model and a grant scoreboard.
// Timeout scenario runs only when UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;
  localparam int DLY  = 10;
  localparam int HOLD = 40;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 65536;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ack;
  logic [2:0]  grant_id;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic        err_timeout;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_last(req_last),
    .req_ack(req_ack), .grant_id(grant_id), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-requester byte queues: {last, data}
  logic [8:0] rq [4][16];
  int rh [4];
  int rt [4];
  // Expected grant sequence
  logic [2:0] ex_id [64];
  logic [7:0] ex_d  [64];
  int eh = 0;
  int et = 0;

  task automatic push_req(input int i, input logic [7:0] d, input logic l);
    rq[i][rt[i]] = {l, d};
    rt[i]++;
  endtask

  task automatic push_exp(input logic [2:0] id, input logic [7:0] d);
    ex_id[et] = id;
    ex_d[et]  = d;
    et++;
  endtask

  bit         outstanding = 0;
  logic [2:0] cur_id = '0;
  logic [7:0] cur_d = '0;
  bit         prev_start = 0;
  bit         err_seen = 0;
  int         ack_count = 0;
  int         grant_count = 0;
  bit         tx_en = 1;
  int         ph = 0;
  int         tcnt = 0;

  initial begin
    for (int i = 0; i < 4; i++) begin rh[i] = 0; rt[i] = 0; end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        outstanding = 0; prev_start = 0; err_seen = 0; ph = 0; tx_busy = 1'b0;
      end else begin
        if (tx_start && !prev_start) begin
          grant_count++;
          if (eh == et) begin
            chk("spurious_grant", 32'(et - eh), 32'd1);
            cur_id = grant_id; cur_d = tx_data;
          end else begin
            chk("grant_id", 32'(grant_id), 32'(ex_id[eh]));
            chk("tx_data", 32'(tx_data), 32'(ex_d[eh]));
            cur_id = ex_id[eh]; cur_d = ex_d[eh]; eh++;
          end
          outstanding = 1;
        end else if (outstanding) begin
          chk("data_hold", 32'(tx_data), 32'(cur_d));
          chk("grant_hold", 32'(grant_id), 32'(cur_id));
        end
        if (req_ack != 4'h0) begin
          chk("req_ack", 32'(req_ack), outstanding ? (32'd1 << cur_id) : 32'd0);
          chk("ack_no_start", 32'(tx_start), 32'd0);
          outstanding = 0;
          ack_count++;
        end
`ifdef UART_ARB_TIMEOUT_EN
        if (err_seen) chk("err_sticky", 32'(err_timeout), 32'd1);
        err_seen = err_seen | err_timeout;
`else
        chk("err_tied", 32'(err_timeout), 32'd0);
`endif
        prev_start = tx_start;
        for (int i = 0; i < 4; i++) if (req_ack[i] && rh[i] < rt[i]) rh[i]++;
        // Transmitter: busy rises DLY cycles after start, stays high HOLD cycles
        case (ph)
          0: if (tx_en && tx_start) begin tcnt = DLY; ph = 1; end
          1: begin tcnt--; if (tcnt == 0) begin tx_busy = 1'b1; tcnt = HOLD; ph = 2; end end
          default: begin tcnt--; if (tcnt == 0) begin tx_busy = 1'b0; ph = 0; end end
        endcase
      end
      for (int i = 0; i < 4; i++) begin
        req[i] = (rh[i] < rt[i]);
        req_data[i*8 +: 8] = rq[i][rh[i] & 15][7:0];
        req_last[i] = rq[i][rh[i] & 15][8];
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin rh[i] = 0; rt[i] = 0; end
    eh = 0; et = 0; ack_count = 0; grant_count = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_acks(input int n, input int budget);
    int b;
    b = 0;
    while (ack_count < n && b < budget) begin @(negedge clk); #1; b++; end
    chk("wait_acks", 32'(ack_count), 32'(n));
  endtask

  task automatic wait_grants(input int n, input int budget);
    int b;
    b = 0;
    while (grant_count < n && b < budget) begin @(negedge clk); #1; b++; end
    chk("wait_grants", 32'(grant_count), 32'(n));
  endtask

  initial begin
    int k;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_req_ack", 32'(req_ack), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Single byte, idle arbiter
    do_reset();
    push_req(0, 8'h55, 1'b1);
    push_exp(3'd0, 8'h55);
    @(negedge clk); #1;
    chk("t1_start_c0", 32'(tx_start), 32'd0);
    @(posedge clk); #1;
    chk("t1_start_c1", 32'(tx_start), 32'd1);
    chk("t1_data", 32'(tx_data), 32'h55);
    chk("t1_gid", 32'(grant_id), 32'd0);
    k = 0;
    while (!tx_busy && k < 100) begin @(negedge clk); #1; k++; end
    while (tx_busy && k < 200) begin @(negedge clk); #1; k++; end
    k = 0;
    while (req_ack[0] !== 1'b1 && k < 20) begin @(negedge clk); #1; k++; end
    chk("t1_ack_latency", 32'(k), 32'd3);
    repeat (30) @(negedge clk);
    #1;
    chk("t1_grants", 32'(grant_count), 32'd1);
    chk("t1_acks", 32'(ack_count), 32'd1);

    // All four requesting, two bytes each
    do_reset();
    for (int r = 0; r < 2; r++) begin
      push_req(0, 8'h10, 1'b1); push_req(1, 8'h21, 1'b1);
      push_req(2, 8'h32, 1'b1); push_req(3, 8'h43, 1'b1);
      push_exp(3'd0, 8'h10); push_exp(3'd1, 8'h21);
      push_exp(3'd2, 8'h32); push_exp(3'd3, 8'h43);
    end
    wait_acks(8, 8 * 80);
    chk("t2_grants", 32'(grant_count), 32'd8);

    // Locked packet from requester 2 with 1 and 3 competing
    do_reset();
    push_req(2, 8'hA0, 1'b0); push_req(2, 8'hA1, 1'b0); push_req(2, 8'hA2, 1'b1);
    push_exp(3'd2, 8'hA0); push_exp(3'd2, 8'hA1); push_exp(3'd2, 8'hA2);
    push_exp(3'd3, 8'h33); push_exp(3'd1, 8'h11);
    wait_grants(1, 20);
    push_req(1, 8'h11, 1'b1); push_req(3, 8'h33, 1'b1);
    wait_acks(5, 5 * 80);

    // Lock owner disappears after a non-final byte
    do_reset();
    push_req(2, 8'hA0, 1'b0);
    push_exp(3'd2, 8'hA0); push_exp(3'd0, 8'h5A);
    wait_grants(1, 20);
    push_req(0, 8'h5A, 1'b1);
    wait_acks(2, 2 * 80);
    push_req(1, 8'h1B, 1'b1); push_req(2, 8'hB2, 1'b1);
    push_exp(3'd1, 8'h1B); push_exp(3'd2, 8'hB2);
    wait_acks(4, 2 * 80);

    // Reset while BUSY
    do_reset();
    push_req(1, 8'h77, 1'b1);
    push_exp(3'd1, 8'h77);
    k = 0;
    while (!tx_busy && k < 100) begin @(negedge clk); #1; k++; end
    repeat (5) @(negedge clk);
    #1;
    push_req(0, 8'h0F, 1'b1);
    chk("t5_pre_gid", 32'(grant_id), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_start", 32'(tx_start), 32'd0);
    chk("t5_rst_ack", 32'(req_ack), 32'd0);
    chk("t5_rst_data", 32'(tx_data), 32'd0);
    chk("t5_rst_gid", 32'(grant_id), 32'd0);
    chk("t5_rst_err", 32'(err_timeout), 32'd0);
    ack_count = 0; grant_count = 0;
    push_exp(3'd0, 8'h0F); push_exp(3'd1, 8'h77);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_acks(2, 2 * 80);

`ifdef UART_ARB_TIMEOUT_EN
    // Transmitter never answers
    do_reset();
    tx_en = 0;
    push_req(0, 8'h99, 1'b1);
    push_exp(3'd0, 8'h99);
    @(posedge clk); #1;
    chk("t6_start_c1", 32'(tx_start), 32'd1);
    k = 1;
    while (tx_start && k < 200) begin @(posedge clk); #1; k++; end
    chk("t6_drop_cycle", 32'(k), 32'd101);
    chk("t6_ack", 32'(req_ack), 32'h1);
    chk("t6_err", 32'(err_timeout), 32'd1);
    @(negedge clk); #1;
    tx_en = 1;
    push_req(1, 8'h66, 1'b1);
    push_exp(3'd1, 8'h66);
    wait_acks(2, 100);
    chk("t6_err_kept", 32'(err_timeout), 32'd1);
`endif

    repeat (5) @(negedge clk);
    #1;
    chk("exp_drained", 32'(eh), 32'(et));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got %0d vectors, expected completion", vectors);
    $fatal(1, "watchdog");
  end
endmodule
